// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - state encoding and cycle constants shared by the Genius game blocks
package genius_pkg;

    localparam int          SYM_W_DEF    = 2;
    // Wide enough to count the 3 s press timeout at 50 MHz
    localparam int          TMR_W_DEF    = 28;
    localparam int unsigned ON_CYC_DEF   = 32'd12_500_000;
    localparam int unsigned OFF_CYC_DEF  = 32'd5_000_000;
    localparam int unsigned TOUT_CYC_DEF = 32'd150_000_000;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH_S    = 4'd1,
        SHOW_ON    = 4'd2,
        SHOW_OFF   = 4'd3,
        FETCH_I    = 4'd4,
        WAIT_PRESS = 4'd5,
        WAIT_REL   = 4'd6,
        PASS       = 4'd7,
        FAIL       = 4'd8
    } state_t;

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - free-running cycle counter with clear and a terminal-count flag
module cycle_timer #(
    parameter int TMR_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [TMR_W-1:0] load,
    output logic             term
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else begin
            count <= count + TMR_W'(1);
        end
    end

    // term is high on the last cycle of an N-cycle phase when load = N-1
    assign term = (count == load);

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - plays back one Genius round and checks the player's presses
module round_sequencer
    import genius_pkg::*;
#(
    parameter int          SYM_W    = SYM_W_DEF,
    parameter int          TMR_W    = TMR_W_DEF,
    parameter int unsigned ON_CYC   = ON_CYC_DEF,
    parameter int unsigned OFF_CYC  = OFF_CYC_DEF,
    parameter int unsigned TOUT_CYC = TOUT_CYC_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            level,
    output logic [3:0]            seq_addr,
    input  logic [SYM_W-1:0]      seq_data,
    input  logic [(2**SYM_W)-1:0] btn,
    output logic                  show_valid,
    output logic [SYM_W-1:0]      show_symbol,
    output logic                  busy,
    output logic                  awaiting,
    output logic                  done,
    output logic                  pass
);

    localparam logic [TMR_W-1:0] ON_LOAD   = TMR_W'(ON_CYC - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD  = TMR_W'(OFF_CYC - 1);
    localparam logic [TMR_W-1:0] TOUT_LOAD = TMR_W'(TOUT_CYC - 1);

    state_t           state;
    state_t           state_d;
    logic [3:0]       step;
    logic [3:0]       level_q;
    logic [SYM_W-1:0] sym_q;
    logic             pass_q;
    logic             busy_q;
    logic [TMR_W-1:0] tmr_load;
    logic             tmr_clear;
    logic             tmr_term;
    logic             btn_any;
    logic             btn_good;
    logic             last_step;

    assign btn_any   = |btn;
    assign btn_good  = $onehot(btn) && btn[sym_q];
    assign last_step = (step == level_q);

    // One timer serves every timed phase; it restarts on each state change
    assign tmr_clear = (state_d != state) || (state == IDLE);

    cycle_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (tmr_clear),
        .load  (tmr_load),
        .term  (tmr_term)
    );

    always_comb begin
        state_d  = state;
        tmr_load = '0;
        case (state)
            IDLE: begin
                if (start) state_d = FETCH_S;
            end
            FETCH_S: state_d = SHOW_ON;
            SHOW_ON: begin
                tmr_load = ON_LOAD;
                if (tmr_term) state_d = SHOW_OFF;
            end
            SHOW_OFF: begin
                tmr_load = OFF_LOAD;
                if (tmr_term) state_d = last_step ? FETCH_I : FETCH_S;
            end
            FETCH_I: state_d = WAIT_PRESS;
            WAIT_PRESS: begin
                tmr_load = TOUT_LOAD;
                // A press seen on the timeout cycle still counts
                if (btn_any) begin
                    state_d = btn_good ? WAIT_REL : FAIL;
                end else if (tmr_term) begin
                    state_d = FAIL;
                end
            end
            WAIT_REL: begin
                if (!btn_any) state_d = last_step ? PASS : FETCH_I;
            end
            PASS:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            step    <= '0;
            level_q <= '0;
            sym_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state  <= state_d;
            busy_q <= (state_d != IDLE);
            if (state == IDLE && start) begin
                level_q <= level;
                step    <= '0;
                pass_q  <= 1'b0;
            end
            if (state == FETCH_S || state == FETCH_I) begin
                sym_q <= seq_data;
            end
            if (state == SHOW_OFF && tmr_term) begin
                step <= last_step ? 4'd0 : step + 4'd1;
            end
            if (state == WAIT_REL && !btn_any && !last_step) begin
                step <= step + 4'd1;
            end
            // Result register moves on the same edge that raises done
            if (state_d == PASS) begin
                pass_q <= 1'b1;
            end else if (state_d == FAIL) begin
                pass_q <= 1'b0;
            end
        end
    end

    assign seq_addr    = (state == IDLE) ? 4'd0 : step;
    assign show_valid  = (state == SHOW_ON);
    assign show_symbol = show_valid ? sym_q : '0;
    assign busy        = busy_q;
    assign awaiting    = (state == WAIT_PRESS);
    assign done        = (state == PASS) || (state == FAIL);
    assign pass        = pass_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - randomized self-checking bench for round_sequencer
module tb_round_sequencer;

    localparam int ON   = 4;
    localparam int OFF  = 2;
    localparam int TOUT = 20;
    localparam int PER  = 1 + ON + OFF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] level = 4'd0;
    logic [3:0] seq_addr;
    logic [1:0] seq_data;
    logic [3:0] btn = 4'd0;
    logic       show_valid;
    logic [1:0] show_symbol;
    logic       busy;
    logic       awaiting;
    logic       done;
    logic       pass;

    logic [1:0] seq_mem [16];
    int         dly     [16];
    logic [3:0] val     [16];
    int         hold    [16];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clock = ~clock;

    assign seq_data = seq_mem[seq_addr];

    round_sequencer #(
        .SYM_W    (2),
        .ON_CYC   (ON),
        .OFF_CYC  (OFF),
        .TOUT_CYC (TOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .level       (level),
        .seq_addr    (seq_addr),
        .seq_data    (seq_data),
        .btn         (btn),
        .show_valid  (show_valid),
        .show_symbol (show_symbol),
        .busy        (busy),
        .awaiting    (awaiting),
        .done        (done),
        .pass        (pass)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [31:0] all_outs();
        return {21'd0, seq_addr, show_valid, show_symbol, busy, awaiting, done, pass};
    endfunction

    // Fill the press plan so every step of a round is answered correctly
    task automatic plan_ok(input int lvl);
        for (int i = 0; i <= lvl; i++) begin
            dly[i]  = $urandom_range(0, TOUT - 1);
            val[i]  = 4'b0001 << seq_mem[i];
            hold[i] = $urandom_range(1, 6);
        end
    endtask

    // Runs one round from the current negedge; expectations come from the game rules
    task automatic run_round(input int lvl);
        int         fail_step;
        logic       exp_pass;
        int         errs;
        int         k;
        int         ph;
        logic       exp_v;
        logic [1:0] exp_sym;
        logic [3:0] exp_addr;
        fail_step = -1;
        for (int i = 0; i <= lvl; i++) begin
            if (fail_step < 0 && (dly[i] >= TOUT || val[i] != (4'b0001 << seq_mem[i])))
                fail_step = i;
        end
        exp_pass = (fail_step < 0);

        level = 4'(lvl);
        start = 1'b1;
        errs  = 0;
        for (int t = 0; t <= (lvl + 1) * PER; t++) begin
            tick();
            k        = t / PER;
            ph       = t % PER;
            exp_v    = (k <= lvl) && (ph >= 1) && (ph <= ON);
            exp_sym  = exp_v ? seq_mem[k] : 2'd0;
            exp_addr = (k <= lvl) ? 4'(k) : 4'd0;
            if (t == 0) check("busy_rise", busy, 1);
            if (show_valid !== exp_v || show_symbol !== exp_sym || seq_addr !== exp_addr ||
                busy !== 1'b1 || awaiting !== 1'b0 || done !== 1'b0)
                errs++;
            start = 1'($urandom_range(0, 1));
            level = 4'($urandom_range(0, 15));
            btn   = (t == (lvl + 1) * PER) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        check("show_trace", errs, 0);

        errs = 0;
        for (int i = 0; i <= lvl; i++) begin
            tick();
            check("await_rise", awaiting, 1);
            check("step_addr", seq_addr, i);
            if (dly[i] >= TOUT) begin
                for (int j = 1; j < TOUT; j++) begin
                    tick();
                    if (awaiting !== 1'b1 || done !== 1'b0) errs++;
                end
                tick();
                break;
            end
            for (int j = 1; j <= dly[i]; j++) begin
                tick();
                if (awaiting !== 1'b1 || done !== 1'b0) errs++;
            end
            btn = val[i];
            tick();
            if (i == fail_step) break;
            if (awaiting !== 1'b0 || done !== 1'b0) errs++;
            for (int j = 1; j < hold[i]; j++) begin
                tick();
                if (awaiting !== 1'b0 || done !== 1'b0) errs++;
            end
            btn = 4'd0;
            tick();
            if (i == lvl) break;
            if (awaiting !== 1'b0 || done !== 1'b0 || seq_addr !== 4'(i + 1)) errs++;
        end
        check("press_phase", errs, 0);
        check("done_pulse", done, 1);
        check("pass_result", pass, exp_pass);

        btn   = 4'd0;
        start = 1'($urandom_range(0, 1));
        level = 4'($urandom_range(0, 15));
        tick();
        start = 1'b0;
        check("done_width", done, 0);
        check("busy_fall", busy, 0);
        check("pass_hold", pass, exp_pass);
    endtask

    initial begin
        int errs;
        int lvl;
        for (int i = 0; i < 16; i++) seq_mem[i] = 2'($urandom_range(0, 3));

        repeat (3) tick();
        check("reset_outs", all_outs(), 0);
        reset = 1'b0;
        tick();

        level = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("in_show", show_valid, 1);
        reset = 1'b1;
        tick();
        check("abort_outs", all_outs(), 0);
        reset = 1'b0;
        errs  = 0;
        repeat (8) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) errs++;
        end
        check("abort_quiet", errs, 0);

        plan_ok(0);
        run_round(0);

        seq_mem[0] = 2'd1; seq_mem[1] = 2'd3; seq_mem[2] = 2'd0;
        plan_ok(2);
        run_round(2);

        seq_mem[0] = 2'd2; seq_mem[1] = 2'd2;
        plan_ok(1);
        val[1] = 4'b0001;
        run_round(1);

        plan_ok(0);
        dly[0] = TOUT;
        run_round(0);

        plan_ok(0);
        dly[0] = TOUT - 1;
        run_round(0);

        seq_mem[0] = 2'd1;
        plan_ok(0);
        val[0] = 4'b0110;
        run_round(0);

        seq_mem[0] = 2'd2; seq_mem[1] = 2'd2;
        plan_ok(1);
        hold[0] = 10;
        run_round(1);

        for (int i = 0; i < 16; i++) seq_mem[i] = 2'($urandom_range(0, 3));
        plan_ok(15);
        run_round(15);

        for (int r = 0; r < 25; r++) begin
            lvl = $urandom_range(0, 6);
            for (int i = 0; i < 16; i++) seq_mem[i] = 2'($urandom_range(0, 3));
            plan_ok(lvl);
            for (int i = 0; i <= lvl; i++) begin
                case ($urandom_range(0, 11))
                    0: dly[i] = TOUT;
                    1: begin
                        val[i] = 4'($urandom_range(1, 15));
                        if (val[i] == (4'b0001 << seq_mem[i])) val[i] = val[i] ^ 4'b1001;
                    end
                    default: ;
                endcase
            end
            run_round(lvl);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
